fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised successor to the pipeline's operand-forwarding logic. Serves NUM_SRC operand read ports; each port is tagged as consumed in ID (branch/jr compare) or EX (ALU operand). For each port it produces a bypass select and a global stall request. A per-register latency scoreboard tracks in-flight multi-cycle (mul/div) writebacks; any read of a register whose result is still pending stalls. The unit sits beside the ID/EX pipeline registers and drives the operand muxes and the PC/IF_ID hold logic.

## Interface
- NUM_SRC, 3, number of operand read ports
- AW, 5, register address width; NUM_REGS = 2**AW
- LAT_W, 3, width of multi-cycle latency field; max latency 2**LAT_W-1
- CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- src_addr  in  NUM_SRC*AW  source register of port i at bits [i*AW +: AW]
- src_in_id  in  NUM_SRC  1 = port i is consumed in ID, 0 = consumed in EX
- src_valid  in  NUM_SRC  port i actually reads its register
- id_ex_we, id_ex_memread  in  1 each  instruction in EX writes a register / is a load
- id_ex_waddr  in  AW
- ex_mem_we, ex_mem_memread  in  1 each
- ex_mem_waddr  in  AW
- mem_wb_we  in  1
- mem_wb_waddr  in  AW
- mdu_issue  in  1  multi-cycle op leaves EX this cycle
- mdu_waddr  in  AW
- mdu_lat  in  LAT_W  cycles until the result is in the register file
- mdu_kill  in  1  flush all pending multi-cycle results
- fwd_sel  out  2*NUM_SRC  per-port select: 00 regfile, 01 ID/EX ALU result, 10 EX/MEM, 11 MEM/WB
- stall  out  1  hold PC and IF/ID, bubble ID/EX
- busy_vec  out  NUM_REGS  scoreboard pending bit per register
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Register 0 never matches, never forwards, and is never busy.
- A producer stage matches port i when its we=1, its waddr equals src_addr[i], its waddr != 0, and src_valid[i]=1.
- EX consumer priority: EX/MEM (10) > MEM/WB (11) > regfile (00). 01 is never emitted for EX consumers.
- ID consumer priority: ID/EX (01) > EX/MEM (10) > MEM/WB (11) > regfile (00). Only the highest-priority matching stage is selected.
- Load-use stall:
  - ID consumer stalls on a match at ID/EX with id_ex_memread, or at EX/MEM with ex_mem_memread.
  - EX consumer stalls on a match at EX/MEM with ex_mem_memread.
- Scoreboard stall: any valid port with src_addr != 0 and busy_vec[src_addr]=1 stalls. This overrides forwarding; fwd_sel is still driven but is don't-care when stall=1.
- stall is the OR over all ports of the load-use and scoreboard conditions.
- Scoreboard: one LAT_W down-counter per register; busy = counter != 0. Each cycle every nonzero counter decrements by 1.
- On mdu_issue with mdu_waddr != 0 and mdu_lat != 0, the target counter loads mdu_lat. This overwrites any pending count (WAW: the newest result wins), and the load takes precedence over that register's decrement in the same cycle. mdu_lat = 0 is a no-op.
- mdu_kill clears all counters and takes precedence over a simultaneous mdu_issue.
- stall_cnt increments on each cycle with stall=1 and saturates at all-ones.

## Timing
- fwd_sel and stall are combinational from the current inputs and the registered scoreboard, with zero latency.
- mdu_issue at edge t with latency L: the register is busy during cycles t+1 through t+L and free in cycle t+L+1.
- The issuing cycle itself is not scoreboard-busy; the issuing instruction is covered by the stage-match logic.
- reset: all counters = 0, busy_vec = 0, stall_cnt = 0. stall and fwd_sel follow the inputs combinationally, so with zero inputs they are 0 and 00.
- Reset asserted mid-operation discards all pending entries on the next edge.

## Structure
- Shared package fwd_pkg holds the FWD_RF/FWD_IDEX/FWD_EXMEM/FWD_MEMWB encoding constants, also used by the datapath operand muxes.
- Sub-module fwd_port_sel is combinational, one per port, generated NUM_SRC times. It computes fwd_sel and the per-port stall from the stage tags and its busy bit.
- The scoreboard counters and stall_cnt live in the top level.

## Test plan
- EX port, src_addr=5, ex_mem_we=1/waddr=5 and mem_wb_we=1/waddr=5 -> fwd_sel=10, stall=0.
- ID port (src_in_id=1), src_addr=31, id_ex_we=1/waddr=31 and ex_mem waddr=31 -> fwd_sel=01; set id_ex_memread=1 -> stall=1.
- src_addr=0 with every stage writing r0 -> fwd_sel=00, stall=0.
- mdu_issue waddr=8, lat=3 -> busy_vec[8]=1 for exactly 3 cycles; EX port reading r8 stalls those 3 cycles; stall_cnt advances by 3.
- Re-issue r8 with lat=5 while 1 cycle remains -> busy for 5 more cycles. Issue r9 alongside mdu_kill -> all busy bits 0 next cycle.
- Force stall for 2**CNT_W+2 cycles (CNT_W overridden to 4) -> stall_cnt holds 15. Assert reset mid-countdown -> busy_vec=0 next cycle.

Source files
------------

// File: rtl/fwd_pkg.sv
// Operand bypass select encodings shared by the hazard unit and the
// datapath operand muxes.
package fwd_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_IDEX  = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b11;

endpackage

// File: rtl/fwd_port_sel.sv
// Per-port bypass select and stall request (combinational).
// In: port address/stage/valid, producer stage tags, scoreboard busy bit.
// Out: sel (FWD_* encoding), stall (load-use or scoreboard hazard).
module fwd_port_sel
    import fwd_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] src_addr,
    input  logic          src_in_id,
    input  logic          src_valid,
    input  logic          id_ex_we,
    input  logic          id_ex_memread,
    input  logic [AW-1:0] id_ex_waddr,
    input  logic          ex_mem_we,
    input  logic          ex_mem_memread,
    input  logic [AW-1:0] ex_mem_waddr,
    input  logic          mem_wb_we,
    input  logic [AW-1:0] mem_wb_waddr,
    input  logic          busy,
    output logic [1:0]    sel,
    output logic          stall
);

    logic rd_nz;
    logic m_idex;
    logic m_exmem;
    logic m_memwb;
    logic lu_stall;

    // r0 is hardwired: a zero source never matches and never waits.
    assign rd_nz   = src_valid && (src_addr != '0);
    assign m_idex  = rd_nz && id_ex_we  && (id_ex_waddr  == src_addr);
    assign m_exmem = rd_nz && ex_mem_we && (ex_mem_waddr == src_addr);
    assign m_memwb = rd_nz && mem_wb_we && (mem_wb_waddr == src_addr);

    always_comb begin
        sel = FWD_RF;
        if (src_in_id && m_idex) begin
            sel = FWD_IDEX;
        end else if (m_exmem) begin
            sel = FWD_EXMEM;
        end else if (m_memwb) begin
            sel = FWD_MEMWB;
        end
    end

    // A load in EX/MEM has no data yet for either consumer; a load in
    // ID/EX only hurts a consumer that needs the value in ID.
    assign lu_stall = (m_exmem && ex_mem_memread) ||
                      (src_in_id && m_idex && id_ex_memread);

    assign stall = lu_stall || (rd_nz && busy);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and hazard unit with a multi-cycle latency scoreboard.
// In: per-port source tags, ID/EX, EX/MEM, MEM/WB producer tags, MDU issue/kill.
// Out: fwd_sel per port, global stall, busy_vec, saturating stall_cnt.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int AW      = 5,
    parameter int LAT_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SRC*AW-1:0] src_addr,
    input  logic [NUM_SRC-1:0]    src_in_id,
    input  logic [NUM_SRC-1:0]    src_valid,
    input  logic                  id_ex_we,
    input  logic                  id_ex_memread,
    input  logic [AW-1:0]         id_ex_waddr,
    input  logic                  ex_mem_we,
    input  logic                  ex_mem_memread,
    input  logic [AW-1:0]         ex_mem_waddr,
    input  logic                  mem_wb_we,
    input  logic [AW-1:0]         mem_wb_waddr,
    input  logic                  mdu_issue,
    input  logic [AW-1:0]         mdu_waddr,
    input  logic [LAT_W-1:0]      mdu_lat,
    input  logic                  mdu_kill,
    output logic [2*NUM_SRC-1:0]  fwd_sel,
    output logic                  stall,
    output logic [2**AW-1:0]      busy_vec,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int NUM_REGS = 2**AW;

    logic [LAT_W-1:0] cnt_q [NUM_REGS];
    logic [LAT_W-1:0] cnt_d [NUM_REGS];
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [NUM_SRC-1:0] port_stall;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_busy
        assign busy_vec[r] = (cnt_q[r] != '0);
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_port
        fwd_port_sel #(.AW(AW)) u_sel (
            .src_addr      (src_addr[i*AW +: AW]),
            .src_in_id     (src_in_id[i]),
            .src_valid     (src_valid[i]),
            .id_ex_we      (id_ex_we),
            .id_ex_memread (id_ex_memread),
            .id_ex_waddr   (id_ex_waddr),
            .ex_mem_we     (ex_mem_we),
            .ex_mem_memread(ex_mem_memread),
            .ex_mem_waddr  (ex_mem_waddr),
            .mem_wb_we     (mem_wb_we),
            .mem_wb_waddr  (mem_wb_waddr),
            .busy          (busy_vec[src_addr[i*AW +: AW]]),
            .sel           (fwd_sel[2*i +: 2]),
            .stall         (port_stall[i])
        );
    end

    assign stall     = |port_stall;
    assign stall_cnt = stall_cnt_q;

    // Kill beats issue; issue beats the per-cycle decrement (newest wins).
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (mdu_kill) begin
                cnt_d[r] = '0;
            end else if (mdu_issue && (mdu_waddr != '0) &&
                         (mdu_lat != '0) && (mdu_waddr == AW'(r))) begin
                cnt_d[r] = mdu_lat;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit (CNT_W=4 so the
// stall counter saturates quickly).
module tb_fwd_hazard_unit;
    import fwd_pkg::*;

    localparam int NS = 3;
    localparam int AW = 5;
    localparam int LW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NS*AW-1:0] src_addr;
    logic [NS-1:0] src_in_id;
    logic [NS-1:0] src_valid;
    logic          id_ex_we, id_ex_memread;
    logic [AW-1:0] id_ex_waddr;
    logic          ex_mem_we, ex_mem_memread;
    logic [AW-1:0] ex_mem_waddr;
    logic          mem_wb_we;
    logic [AW-1:0] mem_wb_waddr;
    logic          mdu_issue;
    logic [AW-1:0] mdu_waddr;
    logic [LW-1:0] mdu_lat;
    logic          mdu_kill;
    logic [2*NS-1:0] fwd_sel;
    logic          stall;
    logic [31:0]   busy_vec;
    logic [CW-1:0] stall_cnt;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .NUM_SRC(NS), .AW(AW), .LAT_W(LW), .CNT_W(CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .src_addr      (src_addr),
        .src_in_id     (src_in_id),
        .src_valid     (src_valid),
        .id_ex_we      (id_ex_we),
        .id_ex_memread (id_ex_memread),
        .id_ex_waddr   (id_ex_waddr),
        .ex_mem_we     (ex_mem_we),
        .ex_mem_memread(ex_mem_memread),
        .ex_mem_waddr  (ex_mem_waddr),
        .mem_wb_we     (mem_wb_we),
        .mem_wb_waddr  (mem_wb_waddr),
        .mdu_issue     (mdu_issue),
        .mdu_waddr     (mdu_waddr),
        .mdu_lat       (mdu_lat),
        .mdu_kill      (mdu_kill),
        .fwd_sel       (fwd_sel),
        .stall         (stall),
        .busy_vec      (busy_vec),
        .stall_cnt     (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        src_addr = '0; src_in_id = '0; src_valid = '0;
        id_ex_we = 0; id_ex_memread = 0; id_ex_waddr = '0;
        ex_mem_we = 0; ex_mem_memread = 0; ex_mem_waddr = '0;
        mem_wb_we = 0; mem_wb_waddr = '0;
        mdu_issue = 0; mdu_waddr = '0; mdu_lat = '0; mdu_kill = 0;
    endtask

    // Inputs change 1 time unit after the edge, checks 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fwd", 32'(fwd_sel), 32'd0);

        // EX port r5: EX/MEM beats MEM/WB
        src_addr = 15'd5; src_valid = 3'b001;
        ex_mem_we = 1; ex_mem_waddr = 5;
        mem_wb_we = 1; mem_wb_waddr = 5;
        #1;
        chk("ex_exmem_sel", 32'(fwd_sel), 32'b000010);
        chk("ex_exmem_stall", 32'(stall), 32'd0);
        tick();
        ex_mem_we = 0;
        #1;
        chk("ex_memwb_sel", 32'(fwd_sel), 32'b000011);
        tick();
        mem_wb_we = 0; id_ex_we = 1; id_ex_waddr = 5;
        #1;
        chk("ex_no_idex", 32'(fwd_sel), 32'b000000);
        tick();

        // Port0 ID r31, port1 EX r31
        clr();
        src_addr = {5'd0, 5'd31, 5'd31};
        src_valid = 3'b011; src_in_id = 3'b001;
        id_ex_we = 1; id_ex_waddr = 31;
        ex_mem_we = 1; ex_mem_waddr = 31;
        #1;
        chk("id_idex_sel", 32'(fwd_sel), 32'b001001);
        chk("id_idex_nostall", 32'(stall), 32'd0);
        tick();
        id_ex_memread = 1;
        #1;
        chk("id_load_use", 32'(stall), 32'd1);
        tick();
        id_ex_we = 0; id_ex_memread = 0; ex_mem_memread = 1;
        src_valid = 3'b010;
        #1;
        chk("ex_load_exmem", 32'(stall), 32'd1);
        tick();
        src_valid = 3'b001;
        #1;
        chk("id_load_exmem", 32'(stall), 32'd1);
        chk("id_exmem_sel", 32'(fwd_sel), 32'b000010);
        tick();

        // Everything targets r0
        clr();
        src_valid = 3'b111; src_in_id = 3'b101;
        id_ex_we = 1; id_ex_memread = 1;
        ex_mem_we = 1; ex_mem_memread = 1; mem_wb_we = 1;
        #1;
        chk("r0_sel", 32'(fwd_sel), 32'd0);
        chk("r0_stall", 32'(stall), 32'd0);
        chk("cnt_after_lu", 32'(stall_cnt), 32'd3);
        tick();

        // Scoreboard: r8 latency 3, EX port reading r8
        clr();
        src_addr = 15'd8; src_valid = 3'b001;
        mdu_issue = 1; mdu_waddr = 8; mdu_lat = 3;
        #1;
        chk("sb_issue_cycle", 32'(stall), 32'd0);
        tick();
        mdu_issue = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("sb_busy", busy_vec, 32'h100);
            chk("sb_stall", 32'(stall), 32'd1);
            tick();
        end
        #1;
        chk("sb_free", busy_vec, 32'h0);
        chk("sb_free_stall", 32'(stall), 32'd0);
        chk("sb_cnt", 32'(stall_cnt), 32'd6);

        // WAW re-issue with one cycle left
        src_valid = 3'b000;
        mdu_issue = 1; mdu_waddr = 8; mdu_lat = 3;
        tick();
        mdu_issue = 0;
        tick();
        tick();
        #1;
        chk("waw_last", busy_vec, 32'h100);
        mdu_issue = 1; mdu_lat = 5;
        tick();
        mdu_issue = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("waw_busy", busy_vec, 32'h100);
            tick();
        end
        #1;
        chk("waw_free", busy_vec, 32'h0);

        // Kill beats a simultaneous issue
        mdu_issue = 1; mdu_waddr = 8; mdu_lat = 7;
        tick();
        mdu_waddr = 9; mdu_lat = 2; mdu_kill = 1;
        #1;
        chk("kill_pre", busy_vec, 32'h100);
        tick();
        clr();
        #1;
        chk("kill_post", busy_vec, 32'h0);
        tick();
        chk("kill_post2", busy_vec, 32'h0);

        // Reset mid-countdown
        mdu_issue = 1; mdu_waddr = 8; mdu_lat = 7;
        tick();
        mdu_issue = 0; reset = 1;
        #1;
        chk("rst_mid_pre", busy_vec, 32'h100);
        tick();
        reset = 0;
        #1;
        chk("rst_mid_busy", busy_vec, 32'h0);
        chk("rst_mid_cnt", 32'(stall_cnt), 32'd0);

        // Saturate the stall counter: 2**4+2 stalled cycles
        src_addr = 15'd5; src_valid = 3'b001;
        ex_mem_we = 1; ex_mem_memread = 1; ex_mem_waddr = 5;
        #1;
        chk("sat_stall", 32'(stall), 32'd1);
        repeat (18) tick();
        chk("sat_cnt", 32'(stall_cnt), 32'd15);
        clr();
        tick();
        chk("sat_hold", 32'(stall_cnt), 32'd15);
        chk("sat_nostall", 32'(stall), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
